csr_sys_pipe: RTL

Parametrised pipeline-register chain that carries decoded instruction words and CSR/system-instruction sideband from decode through the back-end stages. It replaces hand-instantiated per-signal flops with NSTAGES uniform stages. Each stage has its own stall and flush controls and a valid bit, and bubbles are inserted automatically when an upstream stage holds. It also provides an in-flight CSR count so decode can serialise CSR accesses.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/pipe_stage.sv | 38 +++
 rtl/csr_sys_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the CSR/system sideband pipeline: system-instruction class,
// writeback select, the per-stage payload struct and its bubble value.
package riscv_pkg;

  typedef enum logic [2:0] {
    NO_SYS      = 3'd0,
    SYS_ECALL   = 3'd1,
    SYS_EBREAK  = 3'd2,
    SYS_MRET    = 3'd3,
    SYS_WFI     = 3'd4,
    SYS_FENCE_I = 3'd5
  } exc_t;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2,
    RESULT_CSR = 2'd3
  } result_src_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic        csr_read;
    logic        csr_write;
    exc_t        sys;
    result_src_e result_src;
  } csr_stage_t;

  localparam csr_stage_t CSR_STAGE_BUBBLE = '{
    valid:      1'b0,
    instr:      NOP_WORD,
    csr_read:   1'b0,
    csr_write:  1'b0,
    sys:        NO_SYS,
    result_src: RESULT_ALU
  };

  // Bubble with a caller-chosen NOP encoding (the top can override the word).
  function automatic csr_stage_t csr_bubble(input logic [31:0] nop);
    csr_stage_t b;
    b       = CSR_STAGE_BUBBLE;
    b.instr = nop;
    return b;
  endfunction

  function automatic logic csr_active(input csr_stage_t s);
    return s.valid & (s.csr_read | s.csr_write);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One generic pipeline register: flush beats stall, stall holds, bubble_i
// replaces the upstream payload with BUBBLE, otherwise d_i is loaded.
module pipe_stage #(
  parameter type T      = logic [31:0],
  parameter T    BUBBLE = T'('0)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic flush_i,
  input  logic bubble_i,
  input  T     d_i,
  output T     q_o
);

  T q_q;
  T q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = BUBBLE;
    end else if (!stall_i) begin
      q_d = bubble_i ? BUBBLE : d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/csr_sys_pipe.sv
// Decode-to-writeback register chain for instruction words and CSR/system
// sideband. Optional CSR_SYS_PIPE_PERF_EN adds retired/bubble counters.
module csr_sys_pipe
  import riscv_pkg::*;
#(
  parameter int          NSTAGES      = 3,
  parameter int          XLEN         = 32,
  parameter int          CSR_RD_STAGE = 1,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  input  logic [31:0]                        instr_i,
  input  logic                               csr_read_i,
  input  logic                               csr_write_i,
  input  exc_t                               sys_instr_i,
  input  result_src_e                        result_src_i,
  input  logic [NSTAGES-1:0]                 stall_i,
  input  logic [NSTAGES-1:0]                 flush_i,
  input  logic [XLEN-1:0]                    csr_rdata_i,
  output logic [NSTAGES-1:0]                 valid_o,
  output logic [NSTAGES-1:0]                 csr_read_o,
  output logic [NSTAGES-1:0]                 csr_write_o,
  output logic [NSTAGES-1:0][31:0]           instr_o,
  output exc_t [NSTAGES-1:0]                 sys_instr_o,
  output result_src_e [NSTAGES-1:0]          result_src_o,
  output logic [XLEN-1:0]                    csr_rdata_o,
  output logic [$clog2(NSTAGES+1)-1:0]       csr_inflight_o
`ifdef CSR_SYS_PIPE_PERF_EN
  ,
  output logic [63:0]                        retired_o,
  output logic [63:0]                        bubbles_o
`endif
);

  localparam int              NCSR   = NSTAGES - 1 - CSR_RD_STAGE;
  localparam int              CW     = $clog2(NSTAGES + 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam csr_stage_t      BUBBLE = csr_bubble(NOP_INSTR);

  csr_stage_t         in_stage;
  csr_stage_t         stage_d [NSTAGES];
  csr_stage_t         stage_q [NSTAGES];
  logic [NSTAGES-1:0] ins_bubble;

  assign in_stage = '{
    valid:      1'b1,
    instr:      instr_i,
    csr_read:   csr_read_i,
    csr_write:  csr_write_i,
    sys:        sys_instr_i,
    result_src: result_src_i
  };

  // A held upstream stage (or an idle decode) feeds a bubble downstream so
  // nothing is duplicated while the stalled stage keeps its copy.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi]    = in_stage;
        assign ins_bubble[gi] = ~valid_i;
      end else begin : g_body
        assign stage_d[gi]    = stage_q[gi-1];
        assign ins_bubble[gi] = stall_i[gi-1];
      end

      pipe_stage #(
        .T      (csr_stage_t),
        .BUBBLE (BUBBLE)
      ) u_stage (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i[gi]),
        .flush_i  (flush_i[gi]),
        .bubble_i (ins_bubble[gi]),
        .d_i      (stage_d[gi]),
        .q_o      (stage_q[gi])
      );

      assign valid_o[gi]      = stage_q[gi].valid;
      assign instr_o[gi]      = stage_q[gi].instr;
      assign csr_read_o[gi]   = stage_q[gi].csr_read;
      assign csr_write_o[gi]  = stage_q[gi].csr_write;
      assign sys_instr_o[gi]  = stage_q[gi].sys;
      assign result_src_o[gi] = stage_q[gi].result_src;
    end
  endgenerate

  // CSR read data rides alongside stages CSR_RD_STAGE+1 .. NSTAGES-1.
  logic [XLEN-1:0] data_d [NCSR];
  logic [XLEN-1:0] data_q [NCSR];
  logic [NCSR-1:0] data_bubble;

  generate
    for (gi = 0; gi < NCSR; gi++) begin : g_csr_data
      if (gi == 0) begin : g_capture
        assign data_d[gi]      = csr_rdata_i;
        assign data_bubble[gi] = stall_i[CSR_RD_STAGE];
      end else begin : g_forward
        assign data_d[gi]      = data_q[gi-1];
        assign data_bubble[gi] = stall_i[CSR_RD_STAGE+gi];
      end

      pipe_stage #(
        .T      (logic [XLEN-1:0]),
        .BUBBLE ('0)
      ) u_data (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i[CSR_RD_STAGE+1+gi]),
        .flush_i  (flush_i[CSR_RD_STAGE+1+gi]),
        .bubble_i (data_bubble[gi]),
        .d_i      (data_d[gi]),
        .q_o      (data_q[gi])
      );
    end
  endgenerate

  assign csr_rdata_o = data_q[NCSR-1];

  logic [CW-1:0] inflight_d;

  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (csr_active(stage_q[i])) begin
        inflight_d = inflight_d + CNT_ONE;
      end
    end
  end

  assign csr_inflight_o = inflight_d;

`ifdef CSR_SYS_PIPE_PERF_EN
  logic [63:0] retired_q, retired_d;
  logic [63:0] bubbles_q, bubbles_d;

  always_comb begin
    retired_d = retired_q;
    bubbles_d = bubbles_q;
    if (stage_q[NSTAGES-1].valid && !stall_i[NSTAGES-1]) begin
      retired_d = retired_q + 64'd1;
    end
    if (!stage_q[NSTAGES-1].valid) begin
      bubbles_d = bubbles_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_q <= '0;
      bubbles_q <= '0;
    end else begin
      retired_q <= retired_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign retired_o = retired_q;
  assign bubbles_o = bubbles_q;
`endif

endmodule
